de2i150_inport_poller: RTL and testbench

Periodic sampling controller for the 16-bit Avalon input PIO on the de2i150 core. It issues a timed read sequence to the PIO's s1 slave and compares each sample with the previous one. Every change is pushed, with a poll-index timestamp, into a small event FIFO. The FIFO is drained by the accelerator or the CPU, so software does not have to busy-poll the switches or status lines.

---
 rtl/de2i150_inport_poller.sv | 158 +++++++++++++++
 tb/tb_de2i150_inport_poller.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/de2i150_inport_poller.sv
`default_nettype none
// ============================================================================
// Module   : de2i150_inport_poller
// Purpose  : Periodic poller for the 16-bit input PIO; queues timestamped
//            changes into a small event FIFO.
// Revision : 1.0
// ============================================================================
module de2i150_inport_poller #(
  parameter int PERIOD     = 1000,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  output logic [1:0]  pio_address,
  input  logic [31:0] pio_readdata,
  output logic        evt_valid,
  output logic [31:0] evt_data,
  input  logic        evt_pop,
  output logic [6:0]  evt_count,
  output logic        overflow,
  input  logic        clr_ovf,
  output logic        irq
);

  localparam int          c_ADDR_W = $clog2(FIFO_DEPTH);
  localparam logic [15:0] c_RELOAD = 16'(PERIOD - 1);
  localparam logic [6:0]  c_DEPTH  = 7'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_CAPT = 2'd2
  } state_t;

  state_t              r_state;
  logic [15:0]         r_timer;
  logic [15:0]         r_timestamp;
  logic [15:0]         r_last;
  logic                r_first;
  logic [1:0]          r_pio_addr;
  logic [31:0]         r_mem [FIFO_DEPTH];
  logic [c_ADDR_W-1:0] r_rd_ptr;
  logic [c_ADDR_W-1:0] r_wr_ptr;
  logic [6:0]          r_count;
  logic [31:0]         r_head;
  logic                r_ovf;
  logic                r_irq;

  logic [15:0]         w_sample;
  logic                w_unused_rdata;
  logic                w_empty;
  logic                w_full;
  logic                w_push_req;
  logic                w_pop;
  logic                w_push;
  logic                w_drop;
  logic [31:0]         w_entry;
  logic [c_ADDR_W-1:0] w_next_rd;

  assign w_sample       = pio_readdata[15:0];
  assign w_unused_rdata = ^pio_readdata[31:16];
  assign w_empty        = (r_count == 7'd0);
  assign w_full         = (r_count == c_DEPTH);
  assign w_push_req     = (r_state == S_CAPT) && (r_first || (w_sample != r_last));
  assign w_pop          = evt_pop && !w_empty;
  assign w_push         = w_push_req && (!w_full || w_pop);
  assign w_drop         = w_push_req && w_full && !w_pop;
  assign w_entry        = {r_timestamp, w_sample};
  assign w_next_rd      = r_rd_ptr + c_ADDR_W'(1);

  // Timer runs through ADDR/CAPT too, so those cycles fall inside the period.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_timer     <= c_RELOAD;
      r_timestamp <= 16'd0;
      r_last      <= 16'd0;
      r_first     <= 1'b1;
      r_pio_addr  <= 2'd1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (enable) begin
            if (r_timer == 16'd0) begin
              r_timer    <= c_RELOAD;
              r_state    <= S_ADDR;
              r_pio_addr <= 2'd0;
            end else begin
              r_timer <= r_timer - 16'd1;
            end
          end else begin
            r_timer <= c_RELOAD;
            r_first <= 1'b1;
          end
        end
        S_ADDR: begin
          r_timer    <= r_timer - 16'd1;
          r_state    <= S_CAPT;
          r_pio_addr <= 2'd1;
        end
        S_CAPT: begin
          r_timer     <= r_timer - 16'd1;
          r_last      <= w_sample;
          r_first     <= 1'b0;
          r_timestamp <= r_timestamp + 16'd1;
          r_state     <= S_IDLE;
        end
        default: begin
          r_state    <= S_IDLE;
          r_pio_addr <= 2'd1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_entry;
  end

  // Head register tracks the entry that will be at the read pointer after this edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= 7'd0;
      r_head   <= 32'd0;
      r_ovf    <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_ADDR_W'(1);
      if (w_pop)  r_rd_ptr <= w_next_rd;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 7'd1;
        2'b01:   r_count <= r_count - 7'd1;
        default: r_count <= r_count;
      endcase
      if (w_empty) begin
        r_head <= w_push ? w_entry : 32'd0;
      end else if (w_pop) begin
        if (r_count == 7'd1) r_head <= w_push ? w_entry : 32'd0;
        else                 r_head <= r_mem[w_next_rd];
      end
      if (w_drop)       r_ovf <= 1'b1;
      else if (clr_ovf) r_ovf <= 1'b0;
      r_irq <= !w_empty;
    end
  end

  assign pio_address = r_pio_addr;
  assign evt_valid   = !w_empty;
  assign evt_data    = r_head;
  assign evt_count   = r_count;
  assign overflow    = r_ovf;
  assign irq         = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_de2i150_inport_poller.sv
`default_nettype none
// ============================================================================
// Module   : tb_de2i150_inport_poller
// Purpose  : Randomised self-checking bench with a queue-based event model.
// Revision : 1.0
// ============================================================================
module tb_de2i150_inport_poller;

  localparam int PERIOD = 8;
  localparam int DEPTH  = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  pio_address;
  logic [31:0] pio_readdata = 32'd0;
  logic        evt_valid;
  logic [31:0] evt_data;
  logic        evt_pop = 1'b0;
  logic [6:0]  evt_count;
  logic        overflow;
  logic        clr_ovf = 1'b0;
  logic        irq;
  logic [15:0] in_port = 16'd0;

  de2i150_inport_poller #(.PERIOD(PERIOD), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .pio_address(pio_address), .pio_readdata(pio_readdata),
    .evt_valid(evt_valid), .evt_data(evt_data), .evt_pop(evt_pop),
    .evt_count(evt_count), .overflow(overflow), .clr_ovf(clr_ovf), .irq(irq)
  );

  always #5 clk = ~clk;

  // PIO s1 model: in_port is latched only when address 0 is presented; otherwise junk.
  always @(posedge clk)
    pio_readdata <= (pio_address == 2'd0) ? {16'($urandom), in_port} : 32'($urandom);

  logic [31:0] q[$];
  bit          m_ovf, m_first, m_irq, m_capt, m_prev_en, en_run;
  logic [15:0] m_last, m_ts, m_sample;
  int          cyc, last_addr_cyc, n_addr;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf = 0; m_first = 1; m_irq = 0; m_capt = 0; m_prev_en = 0; en_run = 0;
    m_last = 16'd0; m_ts = 16'd0; m_sample = 16'd0; last_addr_cyc = -1;
  endtask

  task automatic compare_outputs();
    check_eq("evt_count", 32'(evt_count), 32'(q.size()));
    check_eq("evt_valid", 32'(evt_valid), 32'(q.size() != 0));
    check_eq("evt_data", evt_data, (q.size() != 0) ? q[0] : 32'd0);
    check_eq("overflow", 32'(overflow), 32'(m_ovf));
    check_eq("irq", 32'(irq), 32'(m_irq));
    if (m_capt) check_eq("capt_addr", 32'(pio_address), 32'd1);
    else        check_eq("addr_range", 32'(pio_address[1]), 32'd0);
  endtask

  // One clock: advance the model using the current inputs, clock, then compare.
  task automatic step();
    bit in_addr, push_req, pop, set_ovf;
    int sz;
    in_addr = (pio_address == 2'd0);
    if (in_addr) begin
      check_eq("poll_while_disabled", 32'(m_prev_en), 32'd1);
      if (last_addr_cyc >= 0 && en_run) check_eq("cadence", 32'(cyc - last_addr_cyc), 32'(PERIOD));
      last_addr_cyc = cyc;
      en_run = 1;
      n_addr++;
    end
    if (!enable) en_run = 0;
    sz       = q.size();
    push_req = m_capt && (m_first || m_sample != m_last);
    pop      = evt_pop && sz != 0;
    set_ovf  = 0;
    if (pop) void'(q.pop_front());
    if (push_req) begin
      if (sz < DEPTH || pop) q.push_back({m_ts, m_sample});
      else set_ovf = 1;
    end
    if (set_ovf) m_ovf = 1;
    else if (clr_ovf) m_ovf = 0;
    if (m_capt) begin
      m_last = m_sample; m_first = 0; m_ts = m_ts + 16'd1;
    end else if (!in_addr && !enable) begin
      m_first = 1;
    end
    if (in_addr) m_sample = in_port;
    m_capt = in_addr;
    m_irq = (sz != 0);
    m_prev_en = enable;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    compare_outputs();
  endtask

  task automatic run_until_addr(input int budget);
    int i;
    for (i = 0; i < budget && pio_address != 2'd0; i++) step();
    if (pio_address != 2'd0) check_eq("addr_timeout", 32'(pio_address), 32'd0);
  endtask

  task automatic do_poll();
    run_until_addr(2 * PERIOD + 2);
    step();
    step();
  endtask

  task automatic drain();
    evt_pop = 1'b1;
    for (int i = 0; i < 2 * DEPTH && q.size() != 0; i++) step();
    evt_pop = 1'b0;
    check_eq("drained", 32'(evt_count), 32'd0);
  endtask

  initial begin
    int snap;
    cyc = 0; n_addr = 0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_outputs();
    check_eq("reset_pio_addr", 32'(pio_address), 32'd1);
    reset_n = 1'b1;

    // Baseline: enable rises at cycle 10.
    in_port = 16'hA5A5;
    repeat (10) step();
    enable = 1'b1;
    run_until_addr(2 * PERIOD + 2);
    step();
    check_eq("addr_one_cycle", 32'(pio_address), 32'd1);
    step();
    check_eq("baseline_valid", 32'(evt_valid), 32'd1);
    check_eq("baseline_data", evt_data, 32'h0000_A5A5);
    check_eq("baseline_irq_late", 32'(irq), 32'd0);
    step();
    check_eq("baseline_irq", 32'(irq), 32'd1);

    // Static input for polls 1 and 2, then change before poll 3.
    do_poll();
    do_poll();
    check_eq("static_count", 32'(evt_count), 32'd1);
    drain();
    in_port = 16'h1234;
    do_poll();
    check_eq("change_data", evt_data, 32'h0003_1234);
    drain();

    // Three queued entries, then reset during CAPT.
    for (int i = 0; i < 3; i++) begin
      in_port = ~in_port;
      do_poll();
    end
    in_port = ~in_port;
    run_until_addr(2 * PERIOD + 2);
    step();
    check_eq("pre_reset_count", 32'(evt_count), 32'd3);
    #1 reset_n = 1'b0;
    #1;
    check_eq("async_rst_count", 32'(evt_count), 32'd0);
    check_eq("async_rst_valid", 32'(evt_valid), 32'd0);
    check_eq("async_rst_data", evt_data, 32'd0);
    check_eq("async_rst_irq", 32'(irq), 32'd0);
    check_eq("async_rst_addr", 32'(pio_address), 32'd1);
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Overflow: toggle every poll for 10 polls without popping.
    for (int i = 0; i < 10; i++) begin
      in_port = ~in_port;
      do_poll();
    end
    check_eq("ovf_count", 32'(evt_count), 32'(DEPTH));
    check_eq("ovf_flag", 32'(overflow), 32'd1);
    check_eq("ts_restart", 32'(evt_data[31:16]), 32'd0);
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    check_eq("clr_ovf_flag", 32'(overflow), 32'd0);
    check_eq("clr_ovf_count", 32'(evt_count), 32'(DEPTH));

    // Full FIFO: pop in the CAPT cycle of a changed poll.
    in_port = ~in_port;
    run_until_addr(2 * PERIOD + 2);
    step();
    evt_pop = 1'b1;
    step();
    evt_pop = 1'b0;
    check_eq("full_pp_count", 32'(evt_count), 32'(DEPTH));
    check_eq("full_pp_head_ts", 32'(evt_data[31:16]), 32'd1);
    drain();

    // Disable during ADDR: the poll completes, then polling stops.
    run_until_addr(2 * PERIOD + 2);
    enable = 1'b0;
    step();
    step();
    snap = n_addr;
    repeat (3 * PERIOD) step();
    check_eq("no_polls_disabled", 32'(n_addr), 32'(snap));
    drain();
    enable = 1'b1;
    do_poll();
    check_eq("reenable_count", 32'(evt_count), 32'd1);
    check_eq("reenable_sample", 32'(evt_data[15:0]), 32'(in_port));
    drain();

    // Randomised traffic.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(11) == 0) in_port = 16'($urandom);
      evt_pop = ($urandom_range(2) == 0);
      clr_ovf = ($urandom_range(19) == 0);
      if ($urandom_range(149) == 0) enable = ~enable;
      step();
    end
    evt_pop = 1'b0;
    clr_ovf = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
